// File: rtl/isp_raw_source_if.sv
// Pixel stream bundle between the raw source and the ISP pipeline input.
//   data_out    : pixel word {sample, 4'h0}, zero when data_en is low
//   data_en     : pixel valid
//   frame_start : high with the first pixel of a frame
//   frame_done  : high with the last pixel of a frame
interface isp_raw_source_if;
  logic [15:0] data_out;
  logic        data_en;
  logic        frame_start;
  logic        frame_done;

  modport master (output data_out, output data_en, output frame_start, output frame_done);
  modport slave  (input  data_out, input  data_en, input  frame_start, input  frame_done);
endinterface

// File: rtl/isp_raw_source.sv
// Raw Bayer test-pattern transmitter: frame/line timing generator with
// horizontal and vertical blanking, Bayer-ordered 12-bit patterns and frame
// progress reporting. Used as an on-chip sensor substitute.
//
// Ports:
//   isp_clk, rst_n        : clock, async active-low reset
//   start_i / stop_i      : start pulse (IDLE only) / sticky stop request
//   continuous_i          : keep sending frames until stop
//   h_active_i, v_active_i: pixels per line, lines per frame (>= 1)
//   h_blank_i, v_blank_i  : blank cycles per line, blank lines per frame
//   pattern_sel_i         : 0 flat, 1 ramp, 2 colour bars, 3 moving diagonal
//   bayer_pattern_i       : 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR
//   r/g/b_lvl_i           : flat-pattern levels
//   pix_o                 : pixel stream (data_out, data_en, frame_start/done)
//   busy_o                : not IDLE
//   frames_sent_o         : completed-frame count, wraps
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// ACTIVE  | emitting pixel (x_q, y_q) of the current line
// HBLANK  | horizontal blanking, cnt_q counts down to 0
// VBLANK  | vertical blanking, cnt_q counts down to 0
module isp_raw_source #(
  parameter int CW = 12
) (
  input  logic             isp_clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             continuous_i,
  input  logic [11:0]      h_active_i,
  input  logic [11:0]      v_active_i,
  input  logic [11:0]      h_blank_i,
  input  logic [11:0]      v_blank_i,
  input  logic [1:0]       pattern_sel_i,
  input  logic [1:0]       bayer_pattern_i,
  input  logic [11:0]      r_lvl_i,
  input  logic [11:0]      g_lvl_i,
  input  logic [11:0]      b_lvl_i,
  isp_raw_source_if.master pix_o,
  output logic             busy_o,
  output logic [15:0]      frames_sent_o
);

  localparam int PAD = 16 - CW;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  state_t      state_q, state_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [24:0] cnt_q, cnt_d;
  logic [2:0]  bar_q, bar_d;
  logic [11:0] bar_cnt_q, bar_cnt_d;
  logic        stop_pend_q, stop_pend_d;
  logic [15:0] frames_q, frames_d;

  // Frame configuration, latched at the start of every frame
  logic [11:0] h_q, h_d, v_q, v_d, hb_q, hb_d, vb_q, vb_d;
  logic [11:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [1:0]  pat_q, pat_d, bay_q, bay_d;

  logic [15:0] data_q, data_d;
  logic        en_q, fs_q, fd_q, fd_d, busy_q;

  logic        new_frame, next_line, end_frame, frame_over, adv;
  logic        cfg_ok_in;
  logic [12:0] line_len;
  logic [24:0] vb_total;
  logic [11:0] bar_w;
  logic [1:0]  colour;
  logic [2:0]  bar_rgb;
  logic [11:0] sample;

  assign cfg_ok_in = (h_active_i != 12'd0) && (v_active_i != 12'd0);
  assign line_len  = {1'b0, h_q} + {1'b0, hb_q};
  assign vb_total  = {13'd0, vb_q} * {12'd0, line_len};
  assign bar_w     = (h_d[11:3] == 9'd0) ? 12'd1 : {3'd0, h_d[11:3]};
  assign frames_d  = frames_q + {15'd0, fd_q};

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    h_d        = h_q;
    v_d        = v_q;
    hb_d       = hb_q;
    vb_d       = vb_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    pat_d      = pat_q;
    bay_d      = bay_q;
    new_frame  = 1'b0;
    next_line  = 1'b0;
    end_frame  = 1'b0;
    frame_over = 1'b0;
    adv        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && cfg_ok_in) new_frame = 1'b1;
      end
      S_ACTIVE: begin
        if (x_q == h_q - 12'd1) begin
          if (hb_q != 12'd0) begin
            state_d = S_HBLANK;
            cnt_d   = {13'd0, hb_q - 12'd1};
          end else if (y_q == v_q - 12'd1) begin
            end_frame = 1'b1;
          end else begin
            next_line = 1'b1;
          end
        end else begin
          x_d = x_q + 12'd1;
          adv = 1'b1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == 25'd0) begin
          if (y_q == v_q - 12'd1) end_frame = 1'b1;
          else                    next_line = 1'b1;
        end else begin
          cnt_d = cnt_q - 25'd1;
        end
      end
      default: begin
        if (cnt_q == 25'd0) frame_over = 1'b1;
        else                cnt_d = cnt_q - 25'd1;
      end
    endcase

    if (end_frame) begin
      if (vb_q != 12'd0) begin
        state_d = S_VBLANK;
        cnt_d   = vb_total - 25'd1;
      end else begin
        frame_over = 1'b1;
      end
    end

    // A stop arriving in the very cycle the frame ends still counts
    if (frame_over) begin
      if (continuous_i && !stop_pend_q && !stop_i && cfg_ok_in) new_frame = 1'b1;
      else                                                     state_d   = S_IDLE;
    end

    if (next_line) begin
      state_d = S_ACTIVE;
      x_d     = 12'd0;
      y_d     = y_q + 12'd1;
    end

    if (new_frame) begin
      state_d = S_ACTIVE;
      x_d     = 12'd0;
      y_d     = 12'd0;
      h_d     = h_active_i;
      v_d     = v_active_i;
      hb_d    = h_blank_i;
      vb_d    = v_blank_i;
      r_d     = r_lvl_i;
      g_d     = g_lvl_i;
      b_d     = b_lvl_i;
      pat_d   = pattern_sel_i;
      bay_d   = bayer_pattern_i;
    end
  end

  // Colour-bar index: advances every bar_w pixels, saturates at 7
  always_comb begin
    bar_d     = bar_q;
    bar_cnt_d = bar_cnt_q;
    if (new_frame || next_line) begin
      bar_d     = 3'd0;
      bar_cnt_d = bar_w - 12'd1;
    end else if (adv) begin
      if (bar_cnt_q == 12'd0) begin
        bar_d     = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
        bar_cnt_d = bar_w - 12'd1;
      end else begin
        bar_cnt_d = bar_cnt_q - 12'd1;
      end
    end
  end

  // Stop is remembered while a frame is in flight; a stop together with an
  // accepted start is kept too, so exactly one frame goes out.
  always_comb begin
    stop_pend_d = (state_d == S_IDLE) ? 1'b0 : (stop_pend_q | stop_i);
  end

  // Pixel for the cycle being entered, so every output is a flop
  always_comb begin
    colour  = {y_d[0], x_d[0]} ^ bay_d;
    // bar order white..black gives R = ~idx[1], G = ~idx[2], B = ~idx[0]
    bar_rgb = {~bar_d[1], ~bar_d[2], ~bar_d[0]};
    case (pat_d)
      2'd0: begin
        case (colour)
          2'd0:    sample = r_d;
          2'd3:    sample = b_d;
          default: sample = g_d;
        endcase
      end
      2'd1: sample = x_d;
      2'd2: begin
        case (colour)
          2'd0:    sample = {12{bar_rgb[2]}};
          2'd3:    sample = {12{bar_rgb[0]}};
          default: sample = {12{bar_rgb[1]}};
        endcase
      end
      default: sample = x_d + y_d + frames_d[11:0];
    endcase
    data_d = (state_d == S_ACTIVE) ? {sample[11 -: CW], {PAD{1'b0}}} : 16'd0;
    fd_d   = (state_d == S_ACTIVE) && (x_d == h_d - 12'd1) && (y_d == v_d - 12'd1);
  end

  always_ff @(posedge isp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= 12'd0;
      y_q         <= 12'd0;
      cnt_q       <= 25'd0;
      bar_q       <= 3'd0;
      bar_cnt_q   <= 12'd0;
      stop_pend_q <= 1'b0;
      frames_q    <= 16'd0;
      h_q         <= 12'd0;
      v_q         <= 12'd0;
      hb_q        <= 12'd0;
      vb_q        <= 12'd0;
      r_q         <= 12'd0;
      g_q         <= 12'd0;
      b_q         <= 12'd0;
      pat_q       <= 2'd0;
      bay_q       <= 2'd0;
      data_q      <= 16'd0;
      en_q        <= 1'b0;
      fs_q        <= 1'b0;
      fd_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      bar_q       <= bar_d;
      bar_cnt_q   <= bar_cnt_d;
      stop_pend_q <= stop_pend_d;
      frames_q    <= frames_d;
      h_q         <= h_d;
      v_q         <= v_d;
      hb_q        <= hb_d;
      vb_q        <= vb_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      pat_q       <= pat_d;
      bay_q       <= bay_d;
      data_q      <= data_d;
      en_q        <= (state_d == S_ACTIVE);
      fs_q        <= new_frame;
      fd_q        <= fd_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign pix_o.data_out    = data_q;
  assign pix_o.data_en     = en_q;
  assign pix_o.frame_start = fs_q;
  assign pix_o.frame_done  = fd_q;
  assign busy_o            = busy_q;
  assign frames_sent_o     = frames_q;

endmodule

// File: tb/tb_isp_raw_source.sv
module tb_isp_raw_source;

  logic        isp_clk;
  logic        rst_n;
  logic        start, stop, cont;
  logic [11:0] h, v, hb, vb, rl, gl, bl;
  logic [1:0]  pat, bay;
  logic        busy;
  logic [15:0] frames;

  isp_raw_source_if pix ();

  isp_raw_source dut (
    .isp_clk        (isp_clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .stop_i         (stop),
    .continuous_i   (cont),
    .h_active_i     (h),
    .v_active_i     (v),
    .h_blank_i      (hb),
    .v_blank_i      (vb),
    .pattern_sel_i  (pat),
    .bayer_pattern_i(bay),
    .r_lvl_i        (rl),
    .g_lvl_i        (gl),
    .b_lvl_i        (bl),
    .pix_o          (pix),
    .busy_o         (busy),
    .frames_sent_o  (frames)
  );

  initial isp_clk = 1'b0;
  always #5 isp_clk = ~isp_clk;

  typedef struct {
    int h, v, hb, vb, pat, bay, r, g, b, cont;
  } cfg_t;

  typedef struct {
    logic        en;
    logic [15:0] data;
    logic        fs, fd, busy;
  } cyc_t;

  typedef struct {
    int          h, v, hb, vb, pat, bay, cyc;
    logic        en;
    logic [15:0] data;
    logic        fd;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_frames = 0;
  cyc_t expq[$];
  cyc_t cap[1024];
  vec_t vecs[15];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference pixel straight from the pattern rules
  function automatic logic [11:0] ref_pix(input cfg_t c, input int x, input int y, input int f);
    int bars[8] = '{7, 6, 3, 2, 5, 4, 1, 0};
    int col, w, bi, comp;
    col = (((y % 2) * 2) + (x % 2)) ^ c.bay;
    w   = (c.h / 8 < 1) ? 1 : c.h / 8;
    bi  = x / w;
    if (bi > 7) bi = 7;
    comp = (col == 0) ? ((bars[bi] >> 2) & 1) : (col == 3) ? (bars[bi] & 1) : ((bars[bi] >> 1) & 1);
    case (c.pat)
      0:       return 12'((col == 0) ? c.r : (col == 3) ? c.b : c.g);
      1:       return 12'(x % 4096);
      2:       return comp != 0 ? 12'hFFF : 12'h000;
      default: return 12'((x + y + f) % 4096);
    endcase
  endfunction

  task automatic model_frames(input cfg_t c, input int nf, input int extra);
    cyc_t e;
    for (int f = 0; f < nf; f++)
      for (int yy = 0; yy < c.v + c.vb; yy++)
        for (int xx = 0; xx < c.h + c.hb; xx++) begin
          e.en   = (yy < c.v) && (xx < c.h);
          e.data = e.en ? {ref_pix(c, xx, yy, exp_frames + f), 4'h0} : 16'h0;
          e.fs   = e.en && xx == 0 && yy == 0;
          e.fd   = e.en && xx == c.h - 1 && yy == c.v - 1;
          e.busy = 1'b1;
          expq.push_back(e);
        end
    for (int i = 0; i < extra; i++) begin
      e = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
      expq.push_back(e);
    end
  endtask

  task automatic apply_cfg(input cfg_t c);
    h = 12'(c.h); v = 12'(c.v); hb = 12'(c.hb); vb = 12'(c.vb);
    pat = 2'(c.pat); bay = 2'(c.bay);
    rl = 12'(c.r); gl = 12'(c.g); bl = 12'(c.b); cont = c.cont[0];
  endtask

  // Leaves the bench 1 time unit after the edge that latched start
  task automatic pulse_start(input logic with_stop);
    @(negedge isp_clk);
    start = 1'b1;
    stop  = with_stop;
    @(posedge isp_clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic run_stream(input string name, input int stop_at, input int start_at);
    int   n, bad, first;
    cyc_t a;
    n = expq.size();
    bad = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge isp_clk);
        #1;
      end
      a = '{pix.data_en, pix.data_out, pix.frame_start, pix.frame_done, busy};
      cap[i] = a;
      if (a != expq[i]) begin
        bad++;
        if (first < 0) first = i;
      end
      start = (i == start_at);
      if (i == stop_at) stop = 1'b1;
    end
    start = 1'b0;
    stop  = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad cycles, first at %0d got en=%b data=0x%h fs=%b fd=%b busy=%b want en=%b data=0x%h fs=%b fd=%b busy=%b",
               name, bad, first, cap[first].en, cap[first].data, cap[first].fs, cap[first].fd, cap[first].busy,
               expq[first].en, expq[first].data, expq[first].fs, expq[first].fd, expq[first].busy);
    end
  endtask

  cfg_t c;
  int   mark;

  initial begin
    vecs[0]  = '{4, 2, 0, 0, 0, 0, 0,  1'b1, 16'h1000, 1'b0};
    vecs[1]  = '{4, 2, 0, 0, 0, 0, 5,  1'b1, 16'h3000, 1'b0};
    vecs[2]  = '{4, 2, 0, 0, 0, 0, 7,  1'b1, 16'h3000, 1'b1};
    vecs[3]  = '{3, 2, 2, 1, 1, 0, 2,  1'b1, 16'h0020, 1'b0};
    vecs[4]  = '{3, 2, 2, 1, 1, 0, 3,  1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{3, 2, 2, 1, 1, 0, 5,  1'b1, 16'h0000, 1'b0};
    vecs[6]  = '{3, 2, 2, 1, 1, 0, 7,  1'b1, 16'h0020, 1'b1};
    vecs[7]  = '{3, 2, 2, 1, 1, 0, 11, 1'b0, 16'h0000, 1'b0};
    vecs[8]  = '{4, 2, 0, 0, 0, 3, 0,  1'b1, 16'h3000, 1'b0};
    vecs[9]  = '{4, 2, 0, 0, 0, 3, 1,  1'b1, 16'h2000, 1'b0};
    vecs[10] = '{16, 1, 0, 0, 2, 0, 1,  1'b1, 16'hFFF0, 1'b0};
    vecs[11] = '{16, 1, 0, 0, 2, 0, 3,  1'b1, 16'hFFF0, 1'b0};
    vecs[12] = '{16, 1, 0, 0, 2, 0, 4,  1'b1, 16'h0000, 1'b0};
    vecs[13] = '{16, 1, 0, 0, 2, 0, 10, 1'b1, 16'hFFF0, 1'b0};
    vecs[14] = '{16, 1, 0, 0, 2, 0, 14, 1'b1, 16'h0000, 1'b0};

    start = 0; stop = 0; cont = 0;
    h = 0; v = 0; hb = 0; vb = 0; pat = 0; bay = 0; rl = 0; gl = 0; bl = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    check("reset_outputs", {pix.data_out, pix.data_en, pix.frame_start, pix.frame_done, busy, frames}, 0);
    @(negedge isp_clk);
    rst_n = 1'b1;

    // Table-driven directed frames
    for (int i = 0; i < 15; i++) begin
      c = '{vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb, vecs[i].pat, vecs[i].bay, 'h100, 'h200, 'h300, 0};
      apply_cfg(c);
      expq.delete();
      model_frames(c, 1, 1);
      pulse_start(1'b0);
      run_stream($sformatf("vec%0d_stream", i), -1, -1);
      exp_frames++;
      check($sformatf("vec%0d_cyc%0d", i, vecs[i].cyc),
            {cap[vecs[i].cyc].en, cap[vecs[i].cyc].data, cap[vecs[i].cyc].fd},
            {vecs[i].en, vecs[i].data, vecs[i].fd});
      check($sformatf("vec%0d_frames", i), frames, exp_frames);
    end

    // Randomised single frames against the reference model
    for (int i = 0; i < 10; i++) begin
      c = '{int'($urandom_range(1, 20)), int'($urandom_range(1, 6)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 0};
      apply_cfg(c);
      expq.delete();
      model_frames(c, 1, 2);
      pulse_start(1'b0);
      // inputs change mid-frame must not matter
      h = 12'd7; pat = ~pat; rl = ~rl;
      run_stream($sformatf("rand%0d_stream", i), -1, -1);
      exp_frames++;
      check($sformatf("rand%0d_frames", i), frames, exp_frames);
    end

    // Continuous with stop during the first frame
    c = '{2, 2, 0, 0, 0, 0, 'h111, 'h222, 'h333, 1};
    apply_cfg(c);
    expq.delete();
    model_frames(c, 1, 6);
    pulse_start(1'b0);
    run_stream("cont_stop_first", 2, -1);
    exp_frames++;
    check("cont_stop_frames", frames, exp_frames);

    // Back-to-back diagonal frames, stop in the third
    c = '{3, 2, 0, 0, 3, 1, 0, 0, 0, 1};
    apply_cfg(c);
    expq.delete();
    model_frames(c, 3, 3);
    pulse_start(1'b0);
    run_stream("cont_back_to_back", 14, -1);
    exp_frames += 3;
    check("b2b_frames", frames, exp_frames);

    // stop and start together while IDLE: exactly one frame
    c = '{3, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    apply_cfg(c);
    expq.delete();
    model_frames(c, 1, 6);
    pulse_start(1'b1);
    run_stream("stop_with_start", -1, -1);
    exp_frames++;
    check("stop_with_start_frames", frames, exp_frames);

    // start while busy, including on the very last cycle of the frame
    c = '{3, 2, 1, 1, 1, 2, 0, 0, 0, 0};
    apply_cfg(c);
    expq.delete();
    model_frames(c, 1, 3);
    pulse_start(1'b0);
    run_stream("start_busy_mid", -1, 3);
    exp_frames++;
    expq.delete();
    model_frames(c, 1, 3);
    pulse_start(1'b0);
    run_stream("start_busy_last", -1, 11);
    exp_frames++;
    check("start_busy_frames", frames, exp_frames);

    // start with a zero dimension is ignored
    c = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    apply_cfg(c);
    pulse_start(1'b0);
    @(posedge isp_clk); #1;
    check("zero_h_ignored", {busy, pix.data_en}, 0);
    c = '{4, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    apply_cfg(c);
    pulse_start(1'b0);
    check("zero_v_ignored", {busy, pix.data_en}, 0);

    // Asynchronous reset at pixel 3
    c = '{4, 2, 0, 0, 3, 0, 0, 0, 0, 0};
    apply_cfg(c);
    pulse_start(1'b0);
    repeat (3) begin
      @(posedge isp_clk); #1;
    end
    check("pre_reset_pixel3", {pix.data_en, pix.data_out}, {1'b1, 12'((3 + exp_frames) % 4096), 4'h0});
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame", {pix.data_out, pix.data_en, pix.frame_start, pix.frame_done, busy, frames}, 0);
    mark = 0;
    repeat (4) begin
      @(posedge isp_clk); #1;
      if (pix.frame_done || pix.data_en) mark++;
    end
    check("reset_no_done", mark, 0);
    @(negedge isp_clk);
    rst_n = 1'b1;
    exp_frames = 0;
    expq.delete();
    model_frames(c, 1, 2);
    pulse_start(1'b0);
    run_stream("after_reset_stream", -1, -1);
    exp_frames++;
    check("after_reset_frames", frames, exp_frames);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
